alarm_bank: RTL and testbench
=============================

// Module: alarm_bank
// PURPOSE
//  Multi-slot alarm engine for the watch. Holds N_ALARM alarm times in {Y,M,D,h,m,s} 8-bit binary.
//  Compares every armed slot against the running clock once per clk1sec edge.
//  Runs a ring/snooze/dismiss state machine and drives alarm_out to the buzzer/LCD layer.
//  Alarm-setting UI loads slots through the wr_* port as packed 48-bit words.
// PARAMETERS
//  N_ALARM     4    number of alarm slots (1..8)
//  RING_SEC    60   seconds alarm_out stays high before auto-timeout
//  SNOOZE_SEC  300  snooze interval in seconds
//  MAX_SNOOZE  3    snoozes allowed per ring event; further snooze pulses ignored
// PORTS
//  clk1sec     in   1         1 Hz tick clock
//  rst         in   1         asynchronous, active-low reset
//  year..second in  8 each    current time, binary, stable at clk1sec edge
//  wr_en       in   1         one-cycle pulse: load slot wr_idx
//  wr_idx      in   $clog2(N_ALARM)  slot to load (min width 1)
//  wr_time     in   48        {year,month,day,hour,minute,second}
//  wr_arm      in   1         armed state written with wr_time
//  ack         in   1         one-cycle dismiss pulse
//  snooze      in   1         one-cycle snooze pulse
//  alarm_out   out  1         high while ringing
//  ring_idx    out  $clog2(N_ALARM)  slot that is ringing or snoozed
//  state       out  2         0 IDLE, 1 RING, 2 SNOOZE
//  armed       out  N_ALARM   per-slot armed flags
//  pending     out  N_ALARM   matches seen while busy, not yet served
//  missed_cnt  out  8         count of rings that timed out
// BEHAVIOUR
//  Reset: all slots 0, armed=0, pending=0, state=IDLE, alarm_out=0, ring_idx=0, timers=0, snooze count=0, missed_cnt=0.
//  Match(i): armed[i] && hh,mm,ss equal && each of Y/M/D equal or slot field==0. Zero field = wildcard.
//   All three date fields zero = daily alarm. Otherwise one-shot.
//  IDLE: if pending!=0, serve lowest pending (clear its bit). Else if any Match, serve lowest matching index.
//   Serve: RING, ring_idx=i, timer=RING_SEC-1, snooze count=0, alarm_out=1 from the same edge.
//  Matches of slots other than ring_idx while RING/SNOOZE set their pending bit.
//  RING: ack -> IDLE. snooze && count<MAX_SNOOZE -> SNOOZE, timer=SNOOZE_SEC-1, count+1.
//   timer==0 -> IDLE, missed.
//   Otherwise timer-1 each edge.
//   ack and snooze together: ack wins.
//   snooze with count==MAX_SNOOZE is ignored; the alarm keeps ringing.
//  SNOOZE: alarm_out=0. timer==0 -> RING with timer=RING_SEC-1. ack -> IDLE (cancel). snooze ignored.
//  Leaving RING/SNOOZE by ack or timeout: one-shot slot -> armed[i]=0. Daily slot stays armed.
//  Write: wr_en stores wr_time and wr_arm, and clears pending[wr_idx].
//   If wr_idx==ring_idx and state!=IDLE, return to IDLE the same edge, no disarm, no missed count.
//   Writes to other slots do not disturb the FSM.
//  A slot written at the edge its time matches does not fire on that edge. Comparison uses pre-write contents.
//  Timers are $clog2(max(RING_SEC,SNOOZE_SEC))+1 bits wide. Snooze count saturates at MAX_SNOOZE.
//  Reset mid-ring: immediate return to reset values, alarm_out low asynchronously.
// CONFIGURATION
//  ALARM_MISSED_LOG_EN defined: missed_cnt increments on every RING timeout and saturates at 255.
//   It clears only on reset.
//  Not defined: no counter logic is built and missed_cnt is tied to 8'd0.
// TESTING
//  1. Write slot0=25/3/14 07:00:00 armed, clock reaches it -> alarm_out=1, ring_idx=0. Ack next edge -> IDLE, armed[0]=0.
//  2. Slot1 daily 06:30:00 -> rings on two consecutive simulated days. armed[1] stays 1 after ack.
//  3. Ring, snooze x3 (SNOOZE_SEC=5) -> re-rings every 5 s. 4th snooze ignored, alarm_out stays 1.
//  4. Slots 0 and 2 both match 08:00:00 -> slot0 rings, pending=4'b0100. Ack -> next edge slot2 rings.
//  5. No ack with RING_SEC=60 -> alarm_out low after 60 edges, state=IDLE. missed_cnt=1 with macro, 0 without.
//  6. rst low mid-RING -> alarm_out=0 immediately. Write to ringing slot -> IDLE, slot still armed.

Source files
------------

// File: rtl/alarm_bank_if.sv
// Alarm engine bus: current time, slot-load port, user buttons and alarm status.
// master drives time/write/buttons; slave (alarm_bank) drives the status outputs.
interface alarm_bank_if #(
  parameter int N_ALARM = 4
) ();
  localparam int IW = (N_ALARM > 1) ? $clog2(N_ALARM) : 1;

  logic [7:0]         year, month, day, hour, minute, second;
  logic               wr_en;
  logic [IW-1:0]      wr_idx;
  logic [47:0]        wr_time;
  logic               wr_arm;
  logic               ack;
  logic               snooze;
  logic               alarm_out;
  logic [IW-1:0]      ring_idx;
  logic [1:0]         state;
  logic [N_ALARM-1:0] armed;
  logic [N_ALARM-1:0] pending;
  logic [7:0]         missed_cnt;

  modport master (
    output year, month, day, hour, minute, second,
    output wr_en, wr_idx, wr_time, wr_arm, ack, snooze,
    input  alarm_out, ring_idx, state, armed, pending, missed_cnt
  );

  modport slave (
    input  year, month, day, hour, minute, second,
    input  wr_en, wr_idx, wr_time, wr_arm, ack, snooze,
    output alarm_out, ring_idx, state, armed, pending, missed_cnt
  );
endinterface

// File: rtl/alarm_bank.sv
// Multi-slot watch alarm: per-slot time compare plus ring/snooze/dismiss FSM.
// Define ALARM_MISSED_LOG_EN to build the saturating missed-ring counter.

// One alarm slot: stored {Y,M,D,h,m,s}; zero date fields are wildcards.
module alarm_slot (
  input  logic        clk1sec,
  input  logic        rst,
  input  logic        we,
  input  logic [47:0] wr_time,
  input  logic [47:0] now,
  output logic        hit,
  output logic        daily
);
  logic [47:0] t;

  always_ff @(posedge clk1sec or negedge rst)
    if (!rst)    t <= '0;
    else if (we) t <= wr_time;

  assign daily = (t[47:24] == 24'd0);
  assign hit   = (t[23:0] == now[23:0])
              && (t[47:40] == 8'd0 || t[47:40] == now[47:40])
              && (t[39:32] == 8'd0 || t[39:32] == now[39:32])
              && (t[31:24] == 8'd0 || t[31:24] == now[31:24]);
endmodule

module alarm_bank #(
  parameter int N_ALARM    = 4,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3
) (
  input  logic         clk1sec,
  input  logic         rst,
  alarm_bank_if.slave  bus
);
  localparam int IW   = (N_ALARM > 1) ? $clog2(N_ALARM) : 1;
  localparam int TMAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
  localparam int TW   = $clog2(TMAX) + 1;
  localparam int CW   = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RING = 2'd1, S_SNOOZE = 2'd2} state_t;

  state_t             st, st_n;
  logic [TW-1:0]      tmr, tmr_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [IW-1:0]      ridx, ridx_n, sel;
  logic [N_ALARM-1:0] armed, armed_n, pend, pend_n;
  logic [N_ALARM-1:0] hit, daily, wmask, m_eff, pend_eff, srv_set, rbit;
  logic [47:0]        now;
  logic               abort, leave;

  assign now = {bus.year, bus.month, bus.day, bus.hour, bus.minute, bus.second};

  alarm_slot u_slot [N_ALARM-1:0] (
    .clk1sec (clk1sec),
    .rst     (rst),
    .we      (wmask),
    .wr_time (bus.wr_time),
    .now     (now),
    .hit     (hit),
    .daily   (daily)
  );

  // The slot being written never fires on the write edge; its pending bit drops.
  always_comb begin
    wmask = '0;
    if (bus.wr_en) wmask[bus.wr_idx] = 1'b1;
    rbit = '0;
    rbit[ridx] = 1'b1;
  end

  assign m_eff    = hit & armed & ~wmask;
  assign pend_eff = pend & ~wmask;
  assign srv_set  = (pend_eff != '0) ? pend_eff : m_eff;
  assign abort    = (st != S_IDLE) && bus.wr_en && (bus.wr_idx == ridx);

  always_comb begin
    sel = '0;
    for (int i = N_ALARM - 1; i >= 0; i--)
      if (srv_set[i]) sel = IW'(i);
  end

  always_ff @(posedge clk1sec or negedge rst)
    if (!rst) begin
      st    <= S_IDLE;
      tmr   <= '0;
      cnt   <= '0;
      ridx  <= '0;
      armed <= '0;
      pend  <= '0;
    end else begin
      st    <= st_n;
      tmr   <= tmr_n;
      cnt   <= cnt_n;
      ridx  <= ridx_n;
      armed <= armed_n;
      pend  <= pend_n;
    end

  always_comb begin
    st_n    = st;
    tmr_n   = tmr;
    cnt_n   = cnt;
    ridx_n  = ridx;
    armed_n = armed;
    pend_n  = pend_eff | (m_eff & ~rbit);
    leave   = 1'b0;
    unique case (st)
      S_IDLE: begin
        pend_n = pend_eff;
        if (srv_set != '0) begin
          st_n        = S_RING;
          ridx_n      = sel;
          tmr_n       = TW'(RING_SEC - 1);
          cnt_n       = '0;
          pend_n      = pend_eff | m_eff;
          pend_n[sel] = 1'b0;
        end
      end
      S_RING: begin
        if (bus.ack) begin
          st_n  = S_IDLE;
          leave = 1'b1;
        end else if (bus.snooze && cnt < CW'(MAX_SNOOZE)) begin
          st_n  = S_SNOOZE;
          tmr_n = TW'(SNOOZE_SEC - 1);
          cnt_n = cnt + 1'b1;
        end else if (tmr == '0) begin
          st_n  = S_IDLE;
          leave = 1'b1;
        end else begin
          tmr_n = tmr - 1'b1;
        end
      end
      S_SNOOZE: begin
        if (bus.ack) begin
          st_n  = S_IDLE;
          leave = 1'b1;
        end else if (tmr == '0) begin
          st_n  = S_RING;
          tmr_n = TW'(RING_SEC - 1);
        end else begin
          tmr_n = tmr - 1'b1;
        end
      end
      default: st_n = S_IDLE;
    endcase
    // Rewriting the active slot cancels it quietly; the write decides its armed bit.
    if (abort) begin
      st_n  = S_IDLE;
      leave = 1'b0;
    end
    if (leave && !daily[ridx]) armed_n[ridx] = 1'b0;
    if (bus.wr_en) armed_n[bus.wr_idx] = bus.wr_arm;
  end

  assign bus.alarm_out = (st == S_RING);
  assign bus.state     = st;
  assign bus.ring_idx  = ridx;
  assign bus.armed     = armed;
  assign bus.pending   = pend;

`ifdef ALARM_MISSED_LOG_EN
  logic       missed;
  logic [7:0] missed_q;

  assign missed = (st == S_RING) && !abort && !bus.ack
               && !(bus.snooze && cnt < CW'(MAX_SNOOZE)) && (tmr == '0);

  always_ff @(posedge clk1sec or negedge rst)
    if (!rst)                            missed_q <= 8'd0;
    else if (missed && missed_q != 8'hFF) missed_q <= missed_q + 8'd1;

  assign bus.missed_cnt = missed_q;
`else
  assign bus.missed_cnt = 8'd0;
`endif
endmodule

// File: tb/tb_alarm_bank.sv
// Directed bench for alarm_bank: seconds-left reference model checked every cycle,
// plus literal expectations for each scenario.
module tb_alarm_bank;
  localparam int N  = 4;
  localparam int RS = 60;
  localparam int SS = 5;
  localparam int MS = 3;
`ifdef ALARM_MISSED_LOG_EN
  localparam bit LOG = 1'b1;
`else
  localparam bit LOG = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad   = 0;

  alarm_bank_if #(.N_ALARM(N)) b ();

  alarm_bank #(.N_ALARM(N), .RING_SEC(RS), .SNOOZE_SEC(SS), .MAX_SNOOZE(MS)) dut (
    .clk1sec (clk),
    .rst     (rst),
    .bus     (b)
  );

  initial forever #10 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [47:0] m_time [N];
  bit [N-1:0]  m_arm, m_pend;
  int          m_state, m_ridx, m_left, m_snz, m_missed;

  function automatic bit fires(input logic [47:0] a, input logic [47:0] now);
    if (a[23:0] != now[23:0]) return 1'b0;
    for (int f = 0; f < 3; f++)
      if (a[47-8*f -: 8] != 8'd0 && a[47-8*f -: 8] != now[47-8*f -: 8]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    logic [47:0] now;
    int wi, pick;
    bit [N-1:0] hits, pend;
    bit done;
    now  = {b.year, b.month, b.day, b.hour, b.minute, b.second};
    wi   = b.wr_en ? int'(b.wr_idx) : -1;
    hits = '0;
    pick = -1;
    done = 1'b0;
    for (int i = 0; i < N; i++)
      if (m_arm[i] && fires(m_time[i], now) && i != wi) hits[i] = 1'b1;
    pend = m_pend;
    if (wi >= 0) pend[wi] = 1'b0;
    if (m_state == 0) begin
      for (int i = N - 1; i >= 0; i--) if (pend[i]) pick = i;
      if (pick < 0) for (int i = N - 1; i >= 0; i--) if (hits[i]) pick = i;
      if (pick >= 0) begin
        m_state = 1; m_ridx = pick; m_left = RS; m_snz = 0;
        pend = pend | hits;
        pend[pick] = 1'b0;
      end
    end else begin
      for (int i = 0; i < N; i++) if (hits[i] && i != m_ridx) pend[i] = 1'b1;
      if (wi == m_ridx) m_state = 0;
      else if (m_state == 1) begin
        if (b.ack) done = 1'b1;
        else if (b.snooze && m_snz < MS) begin m_state = 2; m_left = SS; m_snz++; end
        else begin
          m_left--;
          if (m_left == 0) begin
            done = 1'b1;
            if (LOG && m_missed < 255) m_missed++;
          end
        end
      end else begin
        if (b.ack) done = 1'b1;
        else begin
          m_left--;
          if (m_left == 0) begin m_state = 1; m_left = RS; end
        end
      end
      if (done) begin
        m_state = 0;
        if (m_time[m_ridx][47:24] != 24'd0) m_arm[m_ridx] = 1'b0;
      end
    end
    m_pend = pend;
    if (wi >= 0) begin m_time[wi] = b.wr_time; m_arm[wi] = b.wr_arm; end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) m_time[i] = '0;
      m_arm = '0; m_pend = '0;
      m_state = 0; m_ridx = 0; m_left = 0; m_snz = 0; m_missed = 0;
    end else model_step();
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("m.state",     b.state,      m_state);
      chk("m.alarm_out", b.alarm_out,  m_state == 1);
      chk("m.ring_idx",  b.ring_idx,   m_ridx);
      chk("m.armed",     b.armed,      m_arm);
      chk("m.pending",   b.pending,    m_pend);
      chk("m.missed",    b.missed_cnt, m_missed);
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [47:0] tm(input int y, mo, d, h, mi, s);
    return {8'(y), 8'(mo), 8'(d), 8'(h), 8'(mi), 8'(s)};
  endfunction

  task automatic set_t(input logic [47:0] t);
    {b.year, b.month, b.day, b.hour, b.minute, b.second} = t;
  endtask

  task automatic idle_t();
    set_t(tm(25, 1, 1, 50, 0, 0));
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    #1;
    b.wr_en = 1'b0; b.ack = 1'b0; b.snooze = 1'b0;
  endtask

  task automatic wr(input int idx, input logic [47:0] t, input bit arm);
    b.wr_en = 1'b1; b.wr_idx = 2'(idx); b.wr_time = t; b.wr_arm = arm;
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    b.wr_en = 0; b.wr_idx = 0; b.wr_time = '0; b.wr_arm = 0; b.ack = 0; b.snooze = 0;
    idle_t();
    repeat (2) @(negedge clk);
    #1;
    chk("rst.state", b.state, 0);
    chk("rst.alarm", b.alarm_out, 0);
    chk("rst.armed", b.armed, 0);
    chk("rst.missed", b.missed_cnt, 0);
    #2 rst = 1'b1;

    // 1: one-shot slot 0
    wr(0, tm(25, 3, 14, 7, 0, 0), 1);
    chk("t1.armed0", b.armed, 4'b0001);
    set_t(tm(25, 3, 14, 7, 0, 0)); cyc();
    chk("t1.alarm", b.alarm_out, 1);
    chk("t1.ridx", b.ring_idx, 0);
    idle_t(); b.ack = 1; cyc();
    chk("t1.idle", b.state, 0);
    chk("t1.disarm", b.armed, 4'b0000);

    // 2: daily slot 1 over two days
    wr(1, tm(0, 0, 0, 6, 30, 0), 1);
    for (int d = 14; d <= 15; d++) begin
      set_t(tm(25, 3, d, 6, 30, 0)); cyc();
      chk("t2.alarm", b.alarm_out, 1);
      chk("t2.ridx", b.ring_idx, 1);
      idle_t(); b.ack = 1; cyc();
      chk("t2.armed", b.armed, 4'b0010);
    end

    // 3: three snoozes re-ring after SS seconds, fourth ignored
    set_t(tm(25, 3, 16, 6, 30, 0)); cyc();
    idle_t();
    for (int k = 0; k < MS; k++) begin
      b.snooze = 1; cyc();
      chk("t3.snz", b.state, 2);
      chk("t3.quiet", b.alarm_out, 0);
      repeat (SS - 1) cyc();
      chk("t3.still", b.state, 2);
      cyc();
      chk("t3.rering", b.alarm_out, 1);
    end
    b.snooze = 1; cyc();
    chk("t3.4th", b.alarm_out, 1);
    chk("t3.4th_st", b.state, 1);
    b.ack = 1; cyc();
    chk("t3.idle", b.state, 0);

    // 4: simultaneous matches on slots 0 and 2
    wr(0, tm(0, 0, 0, 8, 0, 0), 1);
    wr(2, tm(25, 0, 0, 8, 0, 0), 1);
    set_t(tm(25, 7, 1, 8, 0, 0)); cyc();
    chk("t4.ridx0", b.ring_idx, 0);
    chk("t4.pend", b.pending, 4'b0100);
    idle_t(); b.ack = 1; cyc();
    chk("t4.ack", b.state, 0);
    cyc();
    chk("t4.ridx2", b.ring_idx, 2);
    chk("t4.alarm2", b.alarm_out, 1);
    chk("t4.pend0", b.pending, 4'b0000);
    b.ack = 1; cyc();
    chk("t4.armed", b.armed, 4'b0011);

    // 5: ring timeout
    wr(3, tm(25, 7, 1, 9, 0, 0), 1);
    set_t(tm(25, 7, 1, 9, 0, 0)); cyc();
    idle_t();
    repeat (RS - 1) cyc();
    chk("t5.lastsec", b.alarm_out, 1);
    cyc();
    chk("t5.timeout", b.alarm_out, 0);
    chk("t5.state", b.state, 0);
    chk("t5.missed", b.missed_cnt, LOG ? 1 : 0);
    chk("t5.armed", b.armed, 4'b0011);

    // 6: async reset mid-ring, then rewrite of the ringing slot
    wr(3, tm(0, 0, 0, 10, 0, 0), 1);
    set_t(tm(25, 7, 1, 10, 0, 0)); cyc();
    chk("t6.ring", b.alarm_out, 1);
    idle_t();
    #2 rst = 1'b0;
    #1;
    chk("t6.rst_alarm", b.alarm_out, 0);
    chk("t6.rst_state", b.state, 0);
    chk("t6.rst_armed", b.armed, 0);
    #2 rst = 1'b1;
    cyc();
    wr(2, tm(0, 0, 0, 11, 0, 0), 1);
    set_t(tm(25, 7, 2, 11, 0, 0)); cyc();
    chk("t6.ring2", b.ring_idx, 2);
    idle_t();
    wr(2, tm(0, 0, 0, 12, 0, 0), 1);
    chk("t6.abort", b.state, 0);
    chk("t6.keep", b.armed, 4'b0100);
    chk("t6.missed", b.missed_cnt, 0);

    // write on the matching edge does not fire; next matching edge does
    set_t(tm(25, 7, 2, 13, 0, 0));
    wr(1, tm(0, 0, 0, 13, 0, 0), 1);
    chk("wm.nofire", b.state, 0);
    cyc();
    chk("wm.fire", b.alarm_out, 1);
    chk("wm.ridx", b.ring_idx, 1);
    idle_t(); b.ack = 1; cyc();
    chk("wm.idle", b.state, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
